// File: rtl/led_panel_bcm_scanner.sv
// led_panel_bcm_scanner: HUB75 panel driver with FM6126 config, BCM row scanning and global dimming
module led_panel_bcm_scanner #(
  parameter int NUM_COLS   = 64,
  parameter int NUM_ROWS   = 32,
  parameter int BIT_DEPTH  = 4,
  parameter int BASE_TICKS = 12,
  parameter int CFG_EN     = 1,
  parameter int CFG_LE1    = 11,
  parameter int CFG_LE2    = 12,
  parameter int LATCH_LE   = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clk_en,
  input  logic       enable,
  input  logic [7:0] brightness,
  output logic       LP_CLK,
  output logic       LATCH,
  output logic       NOE,
  output logic [4:0] ROW,
  output logic       mem_rd,
  output logic [4:0] mem_row,
  output logic [7:0] mem_col,
  output logic [2:0] mem_bit,
  output logic       frame_start,
  output logic       busy,
  output logic [3:0] state
);
  typedef enum logic [3:0] {INIT, CFG1, CFG2, IDLE, LOAD, SHIFT, LATCHD, DISPLAY, NEXT, STOP} state_t;
  state_t st, nxt;
  logic [4:0] row_c;
  logic [2:0] pl_c;
  logic [7:0] cnt, lim;
  logic [31:0] dcnt, on_t, period, on_calc;
  logic [39:0] prod;
  logic pulse_done;
  assign lim = st == CFG1 ? 8'(CFG_LE1) : st == CFG2 ? 8'(CFG_LE2) : 8'(LATCH_LE);
  assign pulse_done = LATCH && LP_CLK && cnt == lim - 8'd1;
  assign period = 32'(BASE_TICKS) << pl_c;
  // wide product so brightness scaling never overflows; +255 rounds up
  assign prod = 40'(period) * 40'(brightness) + 40'd255;
  assign on_calc = 32'(prod >> 8);
  assign mem_row = row_c;
  assign mem_bit = pl_c;
  assign state = st;
  always_comb begin
    nxt = st;
    case (st)
      INIT:    nxt = CFG_EN != 0 ? CFG1 : IDLE;
      CFG1:    nxt = pulse_done ? CFG2 : CFG1;
      CFG2:    nxt = pulse_done ? IDLE : CFG2;
      IDLE:    nxt = enable ? LOAD : STOP;
      LOAD:    nxt = SHIFT;
      SHIFT:   nxt = LP_CLK && mem_col == 8'(NUM_COLS - 1) ? LATCHD : SHIFT;
      LATCHD:  nxt = pulse_done ? DISPLAY : LATCHD;
      DISPLAY: nxt = dcnt == period - 32'd1 ? NEXT : DISPLAY;
      NEXT:    nxt = IDLE;
      STOP:    nxt = enable ? IDLE : STOP;
      default: nxt = INIT;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st <= INIT;
      NOE <= 1'b1;
      LP_CLK <= 1'b0;
      LATCH <= 1'b0;
      mem_rd <= 1'b0;
      frame_start <= 1'b0;
      busy <= 1'b0;
      ROW <= '0;
      mem_col <= '0;
      row_c <= '0;
      pl_c <= '0;
      cnt <= '0;
      dcnt <= '0;
      on_t <= '0;
    end else begin
      frame_start <= 1'b0;
      if (clk_en) begin
        st <= nxt;
        busy <= nxt != IDLE && nxt != STOP;
        case (st)
          CFG1, CFG2, LATCHD: begin
            // one setup tick raises LATCH before the first shift-clock edge
            if (!LATCH) LATCH <= 1'b1;
            else if (!LP_CLK) LP_CLK <= 1'b1;
            else if (pulse_done) begin
              LATCH <= 1'b0;
              LP_CLK <= 1'b0;
              cnt <= '0;
              if (st == LATCHD) begin
                dcnt <= '0;
                on_t <= on_calc;
                NOE <= on_calc == 32'd0;
              end
            end else begin
              LP_CLK <= 1'b0;
              cnt <= cnt + 8'd1;
            end
          end
          IDLE: begin
            NOE <= 1'b1;
            if (enable && row_c == '0 && pl_c == '0) frame_start <= 1'b1;
          end
          LOAD: begin
            ROW <= row_c;
            mem_col <= '0;
            mem_rd <= 1'b1;
          end
          SHIFT: begin
            LP_CLK <= !LP_CLK;
            if (LP_CLK && mem_col == 8'(NUM_COLS - 1)) mem_rd <= 1'b0;
            else if (LP_CLK) mem_col <= mem_col + 8'd1;
          end
          DISPLAY: begin
            if (dcnt == period - 32'd1) NOE <= 1'b1;
            else begin
              dcnt <= dcnt + 32'd1;
              NOE <= !(dcnt + 32'd1 < on_t);
            end
          end
          NEXT: begin
            NOE <= 1'b1;
            if (pl_c == 3'(BIT_DEPTH - 1)) begin
              pl_c <= '0;
              row_c <= row_c == 5'(NUM_ROWS - 1) ? '0 : row_c + 5'd1;
            end else pl_c <= pl_c + 3'd1;
          end
          STOP: NOE <= 1'b1;
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_led_panel_bcm_scanner.sv
// tb_led_panel_bcm_scanner: scoreboard bench checking per-row/bit-plane scan segments
module tb_led_panel_bcm_scanner;
  logic clk, rst_n, clk_en, enable;
  logic [7:0] brightness;
  logic LP_CLK, LATCH, NOE, mem_rd, frame_start, busy;
  logic [4:0] ROW, mem_row;
  logic [7:0] mem_col;
  logic [2:0] mem_bit;
  logic [3:0] state;
  int n_vec, n_err, ph;
  logic div3;
  typedef struct {int row; int pl; int low; int disp; int fs;} seg_t;
  seg_t q[$];

  led_panel_bcm_scanner #(
    .NUM_COLS(4), .NUM_ROWS(2), .BIT_DEPTH(2), .BASE_TICKS(4),
    .CFG_EN(1), .CFG_LE1(11), .CFG_LE2(12), .LATCH_LE(3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .enable(enable), .brightness(brightness),
    .LP_CLK(LP_CLK), .LATCH(LATCH), .NOE(NOE), .ROW(ROW), .mem_rd(mem_rd),
    .mem_row(mem_row), .mem_col(mem_col), .mem_bit(mem_bit),
    .frame_start(frame_start), .busy(busy), .state(state)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    clk_en = 1;
    ph = 0;
    forever begin
      @(posedge clk);
      #1;
      if (div3) begin
        ph = (ph + 1) % 3;
        clk_en = ph == 0;
      end else begin
        ph = 0;
        clk_en = 1;
      end
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic push_seg(input int r, input int b, input int br, input int dv);
    seg_t s;
    int p;
    p = 4 << b;
    s.row = r;
    s.pl = b;
    s.disp = p * dv;
    s.low = ((p * br + 255) >> 8) * dv;
    s.fs = (r == 0 && b == 0) ? 1 : 0;
    q.push_back(s);
  endtask

  task automatic wait_state(input string tag, input logic [3:0] s, input int lim);
    int n;
    n = 0;
    while (state != s && n < lim) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(tag, int'(state), int'(s));
  endtask

  task automatic wait_empty(input string tag);
    int n;
    n = 0;
    while (q.size() != 0 && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(tag, q.size(), 0);
  endtask

  // monitor: accumulates per-segment activity and scores it when DISPLAY ends
  initial begin
    int lp_n, col_bad, lat_n, low_n, disp_n, fs_n, row_bad, c1, c2;
    logic p_lp;
    logic [3:0] p_st;
    logic [4:0] p_row;
    seg_t e;
    {lp_n, col_bad, lat_n, low_n, disp_n, fs_n, row_bad, c1, c2} = '0;
    p_lp = 0;
    p_st = 0;
    p_row = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        {lp_n, col_bad, lat_n, low_n, disp_n, fs_n, row_bad, c1, c2} = '0;
      end else begin
        if (LP_CLK && !p_lp) begin
          if (state == 4'd5) begin
            if (mem_col != 8'(lp_n) || LATCH || !mem_rd) col_bad++;
            lp_n++;
          end
          if (LATCH && state == 4'd6) lat_n++;
          if (LATCH && state == 4'd1) c1++;
          if (LATCH && state == 4'd2) c2++;
        end
        if (!NOE) low_n++;
        if (!NOE && ROW != p_row) row_bad++;
        if (state == 4'd7) disp_n++;
        if (frame_start) fs_n++;
        if (p_st == 4'd1 && state != 4'd1) check("cfg1_pulses", c1, 11);
        if (p_st == 4'd2 && state != 4'd2) check("cfg2_pulses", c2, 12);
        if (p_st == 4'd7 && state == 4'd8) begin
          if (q.size() == 0) check("seg_expected", q.size(), 1);
          else begin
            e = q.pop_front();
            check("seg_row", int'(mem_row), e.row);
            check("seg_ROW", int'(ROW), e.row);
            check("seg_bit", int'(mem_bit), e.pl);
            check("seg_lp_pulses", lp_n, 4);
            check("seg_col_seq", col_bad, 0);
            check("seg_latch_pulses", lat_n, 3);
            check("seg_noe_low", low_n, e.low);
            check("seg_display_len", disp_n, e.disp);
            check("seg_frame_start", fs_n, e.fs);
            check("seg_row_hold", row_bad, 0);
          end
          {lp_n, col_bad, lat_n, low_n, disp_n, fs_n, row_bad} = '0;
        end
      end
      p_lp = LP_CLK;
      p_st = state;
      p_row = ROW;
    end
  end

  initial begin
    int n;
    n_vec = 0;
    n_err = 0;
    rst_n = 0;
    enable = 0;
    brightness = 8'd255;
    div3 = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_state", int'(state), 0);
    check("rst_noe", int'(NOE), 1);
    check("rst_lp", int'(LP_CLK), 0);
    check("rst_latch", int'(LATCH), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_mem_rd", int'(mem_rd), 0);
    check("rst_row", int'(ROW), 0);
    check("rst_col", int'(mem_col), 0);
    check("rst_fs", int'(frame_start), 0);
    rst_n = 1;
    @(posedge clk);
    #1;
    check("init_to_cfg1", int'(state), 1);
    check("cfg_busy", int'(busy), 1);
    wait_state("cfg_to_stop", 4'd9, 300);
    check("stop_noe", int'(NOE), 1);
    check("stop_busy", int'(busy), 0);
    push_seg(0, 0, 255, 1);
    push_seg(0, 1, 255, 1);
    push_seg(1, 0, 255, 1);
    push_seg(1, 1, 255, 1);
    push_seg(0, 0, 255, 1);
    enable = 1;
    wait_empty("drain_full");
    brightness = 8'd128;
    push_seg(0, 1, 128, 1);
    push_seg(1, 0, 128, 1);
    push_seg(1, 1, 128, 1);
    wait_empty("drain_half");
    brightness = 8'd0;
    push_seg(0, 0, 0, 1);
    push_seg(0, 1, 0, 1);
    wait_empty("drain_dark");
    brightness = 8'd255;
    push_seg(1, 0, 255, 1);
    n = 0;
    while (!(state == 4'd5 && mem_row == 5'd1 && mem_bit == 3'd0) && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("shift_r1b0", int'(state), 5);
    enable = 0;
    wait_empty("drain_stop");
    wait_state("enter_stop", 4'd9, 100);
    check("stop_mem_row", int'(mem_row), 1);
    check("stop_mem_bit", int'(mem_bit), 1);
    check("stop_noe2", int'(NOE), 1);
    repeat (10) @(posedge clk);
    #1;
    check("stop_hold", int'(state), 9);
    push_seg(1, 1, 255, 1);
    push_seg(0, 0, 255, 1);
    enable = 1;
    wait_empty("drain_resume");
    div3 = 1;
    brightness = 8'd128;
    push_seg(0, 1, 128, 3);
    push_seg(1, 0, 128, 3);
    push_seg(1, 1, 128, 3);
    wait_empty("drain_div3");
    wait_state("display_pre_rst", 4'd7, 500);
    repeat (2) @(posedge clk);
    #1;
    check("pre_rst_noe", int'(NOE), 0);
    #3;
    rst_n = 0;
    #1;
    check("async_rst_state", int'(state), 0);
    check("async_rst_noe", int'(NOE), 1);
    check("async_rst_busy", int'(busy), 0);
    div3 = 0;
    enable = 0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1;
    wait_state("rerun_cfg_stop", 4'd9, 300);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
